// File: rtl/row_col_scan_ptr_if.sv
// Bus bundle for the 2-D scan pointer: control inputs, load values,
// registered pointers and status pulses.
interface row_col_scan_ptr_if #(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 3
);
  logic                start;
  logic                stop;
  logic                en;
  logic [1:0]          mode;
  logic                load;
  logic [ROW_BITS-1:0] load_row;
  logic [COL_BITS-1:0] load_col;
  logic [ROW_BITS-1:0] row_ptr;
  logic [COL_BITS-1:0] col_ptr;
  logic                row_wrap;
  logic                frame_done;
  logic                busy;

  modport master (
    output start, stop, en, mode, load, load_row, load_col,
    input  row_ptr, col_ptr, row_wrap, frame_done, busy
  );

  modport slave (
    input  start, stop, en, mode, load, load_row, load_col,
    output row_ptr, col_ptr, row_wrap, frame_done, busy
  );
endinterface

// File: rtl/row_col_scan_ptr.sv
// 2-D scan pointer generator: column sub-counter with exact wrap, row stepping
// in UP / DOWN / PINGPONG / ONESHOT order, start/stop control, pointer load and
// single-cycle row_wrap / frame_done pulses aligned with the new pointers.
module row_col_scan_ptr #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 8,
  parameter int ROW_BITS = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int COL_BITS = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  row_col_scan_ptr_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] M_UP   = 2'd0;
  localparam logic [1:0] M_DOWN = 2'd1;
  localparam logic [1:0] M_PP   = 2'd2;
  localparam logic [1:0] M_ONE  = 2'd3;

  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NUM_ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(NUM_COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);
  localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);

  state_t              state, state_nxt;
  logic [1:0]          mode_q;
  logic                dir_down;
  logic [ROW_BITS-1:0] row_cur;
  logic [COL_BITS-1:0] col_cur;
  logic                row_wrap_q;
  logic                frame_done_q;

  logic                step;
  logic                col_last;
  logic [ROW_BITS-1:0] row_nxt;
  logic                dir_nxt;
  logic                frame_hit;
  logic                oneshot_end;

  assign step        = (state == RUN) && bus.en && !bus.stop && !bus.load;
  assign col_last    = (col_cur == COL_LAST);
  assign oneshot_end = step && col_last && frame_hit && (mode_q == M_ONE);

  // Row successor for the latched scan mode; dir_down tracks the pingpong leg.
  always_comb begin
    row_nxt   = row_cur;
    dir_nxt   = dir_down;
    frame_hit = 1'b0;
    case (mode_q)
      M_DOWN: begin
        if (row_cur == '0) begin
          row_nxt   = ROW_LAST;
          frame_hit = 1'b1;
        end else begin
          row_nxt = row_cur - ROW_ONE;
        end
      end
      M_PP: begin
        if (NUM_ROWS == 1) begin
          row_nxt   = '0;
          dir_nxt   = 1'b0;
          frame_hit = 1'b1;
        end else if (!dir_down || row_cur == '0) begin
          // Rising leg; a loaded row 0 with dir down also restarts upward.
          if (row_cur == ROW_LAST) begin
            row_nxt   = ROW_LAST - ROW_ONE;
            // With two rows the turnaround lands on row 0 and closes the frame.
            dir_nxt   = (ROW_LAST != ROW_ONE);
            frame_hit = (ROW_LAST == ROW_ONE);
          end else begin
            row_nxt = row_cur + ROW_ONE;
            dir_nxt = 1'b0;
          end
        end else begin
          row_nxt = row_cur - ROW_ONE;
          if (row_cur == ROW_ONE) begin
            dir_nxt   = 1'b0;
            frame_hit = 1'b1;
          end
        end
      end
      default: begin
        // UP and ONESHOT share the ascending order.
        if (row_cur == ROW_LAST) begin
          row_nxt   = '0;
          frame_hit = 1'b1;
        end else begin
          row_nxt = row_cur + ROW_ONE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: start/stop commands and the end of a oneshot frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (bus.stop || oneshot_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy follows the state register; pointers and pulses are registered.
  always_comb begin
    bus.busy       = (state == RUN);
    bus.row_ptr    = row_cur;
    bus.col_ptr    = col_cur;
    bus.row_wrap   = row_wrap_q;
    bus.frame_done = frame_done_q;
  end

  // Pointer, mode, direction and pulse registers; load outranks start-init and step.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cur      <= '0;
      col_cur      <= '0;
      dir_down     <= 1'b0;
      mode_q       <= M_UP;
      row_wrap_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_wrap_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.load) begin
        row_cur <= (bus.load_row > ROW_LAST) ? ROW_LAST : bus.load_row;
        col_cur <= (bus.load_col > COL_LAST) ? COL_LAST : bus.load_col;
        if (state == IDLE && bus.start) begin
          mode_q   <= bus.mode;
          dir_down <= 1'b0;
        end
      end else if (state == IDLE && bus.start) begin
        mode_q   <= bus.mode;
        dir_down <= 1'b0;
        row_cur  <= (bus.mode == M_DOWN) ? ROW_LAST : '0;
        col_cur  <= '0;
      end else if (step) begin
        if (!col_last) begin
          col_cur <= col_cur + COL_ONE;
        end else begin
          col_cur    <= '0;
          row_cur    <= row_nxt;
          dir_down   <= dir_nxt;
          row_wrap_q <= 1'b1;
          if (frame_hit) begin
            frame_done_q <= 1'b1;
            // Mode changes are only picked up on a frame boundary.
            if (mode_q != M_ONE) mode_q <= bus.mode;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_row_col_scan_ptr.sv
// Directed bench for row_col_scan_ptr: a 3x5 instance for UP/DOWN/ONESHOT,
// load, stop and reset scenarios, and a 4x1 instance for PINGPONG.
module tb_row_col_scan_ptr;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  row_col_scan_ptr_if #(.ROW_BITS(2), .COL_BITS(3)) sa ();
  row_col_scan_ptr_if #(.ROW_BITS(2), .COL_BITS(1)) sb ();

  row_col_scan_ptr #(.NUM_ROWS(3), .NUM_COLS(5)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (sa)
  );

  row_col_scan_ptr #(.NUM_ROWS(4), .NUM_COLS(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (sb)
  );

  // got/expected are packed {row, col, row_wrap, frame_done, busy}
  logic [7:0] got_a, exp_a;
  logic [5:0] got_b, exp_b;

  task automatic tick;
    @(posedge clk);
    #1;
    got_a = {sa.row_ptr, sa.col_ptr, sa.row_wrap, sa.frame_done, sa.busy};
    got_b = {sb.row_ptr, sb.col_ptr, sb.row_wrap, sb.frame_done, sb.busy};
  endtask

  task automatic idle_inputs;
    sa.start = 0; sa.stop = 0; sa.en = 0; sa.mode = 0;
    sa.load = 0; sa.load_row = 0; sa.load_col = 0;
    sb.start = 0; sb.stop = 0; sb.en = 0; sb.mode = 0;
    sb.load = 0; sb.load_row = 0; sb.load_col = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if (got_a !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_a: got {r,c,wrap,fd,busy}=%b expected %b", got_a, 8'h00);
    end
    n_checks++;
    if (got_b !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_b: got %b expected %b", got_b, 6'h00);
    end
  endtask

  task automatic test_up;
    sa.mode = 2'd0; sa.start = 1; tick(); sa.start = 0;
    n_checks++;
    if (got_a !== {2'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL up_start: got %b expected %b", got_a, {2'd0, 3'd0, 3'b001});
    end
    for (int i = 1; i <= 15; i++) begin
      sa.en = 1; tick();
      exp_a = {2'((i / 5) % 3), 3'(i % 5), (i % 5 == 0), (i == 15), 1'b1};
      n_checks++;
      if (got_a !== exp_a) begin
        n_fail++;
        $display("FAIL up_step%0d: got %b expected %b", i, got_a, exp_a);
      end
    end
    sa.en = 0; sa.stop = 1; tick(); sa.stop = 0;
    n_checks++;
    if (got_a !== 8'h00) begin
      n_fail++;
      $display("FAIL up_stop: got %b expected %b", got_a, 8'h00);
    end
  endtask

  task automatic test_down;
    sa.mode = 2'd1; sa.start = 1; tick(); sa.start = 0;
    n_checks++;
    if (got_a !== {2'd2, 3'd0, 3'b001}) begin
      n_fail++;
      $display("FAIL down_start: got %b expected %b", got_a, {2'd2, 3'd0, 3'b001});
    end
    for (int i = 1; i <= 15; i++) begin
      sa.en = 1; tick();
      exp_a = {2'(2 - (i / 5) % 3), 3'(i % 5), (i % 5 == 0), (i == 15), 1'b1};
      n_checks++;
      if (got_a !== exp_a) begin
        n_fail++;
        $display("FAIL down_step%0d: got %b expected %b", i, got_a, exp_a);
      end
    end
    sa.en = 0; sa.stop = 1; tick(); sa.stop = 0;
  endtask

  task automatic test_mode_change;
    sa.mode = 2'd0; sa.start = 1; tick(); sa.start = 0;
    sa.mode = 2'd1;  // requested mid-frame; UP order must continue
    for (int i = 1; i <= 20; i++) begin
      sa.en = 1; tick();
      if (i <= 15)
        exp_a = {2'((i / 5) % 3), 3'(i % 5), (i % 5 == 0), (i == 15), 1'b1};
      else
        exp_a = {(i == 20) ? 2'd2 : 2'd0, 3'(i % 5), (i == 20), (i == 20), 1'b1};
      n_checks++;
      if (got_a !== exp_a) begin
        n_fail++;
        $display("FAIL mode_chg_step%0d: got %b expected %b", i, got_a, exp_a);
      end
    end
    sa.en = 0; sa.stop = 1; sa.mode = 2'd0; tick(); sa.stop = 0;
  endtask

  task automatic test_pingpong;
    logic [1:0] rows [12] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                              2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    sb.mode = 2'd2; sb.start = 1; tick(); sb.start = 0;
    n_checks++;
    if (got_b !== {2'd0, 1'b0, 3'b001}) begin
      n_fail++;
      $display("FAIL pp_start: got %b expected %b", got_b, {2'd0, 1'b0, 3'b001});
    end
    for (int i = 0; i < 12; i++) begin
      sb.en = 1; tick();
      exp_b = {rows[i], 1'b0, 1'b1, (rows[i] == 2'd0), 1'b1};
      n_checks++;
      if (got_b !== exp_b) begin
        n_fail++;
        $display("FAIL pp_step%0d: got %b expected %b", i + 1, got_b, exp_b);
      end
    end
    sb.en = 0; sb.stop = 1; tick(); sb.stop = 0;
  endtask

  task automatic test_oneshot;
    for (int run = 0; run < 2; run++) begin
      sa.mode = 2'd3; sa.start = 1; tick(); sa.start = 0;
      for (int i = 1; i <= 15; i++) begin
        sa.en = 1; tick();
        exp_a = {2'((i / 5) % 3), 3'(i % 5), (i % 5 == 0), (i == 15), (i != 15)};
        n_checks++;
        if (got_a !== exp_a) begin
          n_fail++;
          $display("FAIL oneshot_run%0d_step%0d: got %b expected %b", run, i, got_a, exp_a);
        end
      end
      for (int i = 0; i < 3; i++) begin
        sa.en = 1; tick();
        n_checks++;
        if (got_a !== 8'h00) begin
          n_fail++;
          $display("FAIL oneshot_hold%0d: got %b expected %b", i, got_a, 8'h00);
        end
      end
      sa.en = 0;
    end
  endtask

  task automatic test_stop;
    sa.mode = 2'd0; sa.start = 1; tick(); sa.start = 0;
    sa.en = 1; tick(); tick();
    sa.stop = 1; tick(); sa.stop = 0; sa.en = 0;
    n_checks++;
    if (got_a !== {2'd0, 3'd2, 3'b000}) begin
      n_fail++;
      $display("FAIL stop_beats_en: got %b expected %b", got_a, {2'd0, 3'd2, 3'b000});
    end
  endtask

  task automatic test_load;
    sa.mode = 2'd0; sa.start = 1; tick(); sa.start = 0;
    sa.load = 1; sa.load_row = 2'(7); sa.load_col = 3'd2; sa.en = 1; tick();
    sa.load = 0;
    n_checks++;
    if (got_a !== {2'd2, 3'd2, 3'b001}) begin
      n_fail++;
      $display("FAIL load_clamp: got %b expected %b", got_a, {2'd2, 3'd2, 3'b001});
    end
    tick();
    n_checks++;
    if (got_a !== {2'd2, 3'd3, 3'b001}) begin
      n_fail++;
      $display("FAIL load_then_step: got %b expected %b", got_a, {2'd2, 3'd3, 3'b001});
    end
    sa.en = 0; sa.stop = 1; sa.start = 1; tick(); sa.stop = 0; sa.start = 0;
    n_checks++;
    if (got_a !== {2'd2, 3'd3, 3'b000}) begin
      n_fail++;
      $display("FAIL stop_start: got %b expected %b", got_a, {2'd2, 3'd3, 3'b000});
    end
    sa.en = 1; tick(); tick(); sa.en = 0;
    n_checks++;
    if (got_a !== {2'd2, 3'd3, 3'b000}) begin
      n_fail++;
      $display("FAIL idle_en: got %b expected %b", got_a, {2'd2, 3'd3, 3'b000});
    end
  endtask

  task automatic test_reset_mid_run;
    sa.mode = 2'd0; sa.start = 1; tick(); sa.start = 0;
    for (int i = 0; i < 8; i++) begin
      sa.en = 1; tick();
    end
    n_checks++;
    if (got_a !== {2'd1, 3'd3, 3'b001}) begin
      n_fail++;
      $display("FAIL mid_run_pos: got %b expected %b", got_a, {2'd1, 3'd3, 3'b001});
    end
    reset = 1; tick(); reset = 0; sa.en = 0;
    n_checks++;
    if (got_a !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %b expected %b", got_a, 8'h00);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_up();
    test_down();
    test_mode_change();
    test_pingpong();
    test_oneshot();
    test_stop();
    test_load();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
